// File: rtl/spi.sv
// rtl/spi.sv - 16-bit free-running SPI master transmitter, MSB first, CPOL=0
module spi (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] datain,
  output logic        spi_cs_l,
  output logic        spi_sclk,
  output logic        spi_data,
  output logic [4:0]  counter
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2
  } state_t;

  localparam logic [4:0] FRAME_BITS = 5'd16;

  state_t      state_q, state_d;
  logic [15:0] word_q,  word_d;
  logic        cs_l_q,  cs_l_d;
  logic        sclk_q,  sclk_d;
  logic        data_q,  data_d;
  logic [4:0]  cnt_q,   cnt_d;

  logic        cnt_valid;
  logic [3:0]  bit_sel;

  // Anything above 16 is unreachable; treat it as corruption and resync.
  assign cnt_valid = (cnt_q <= FRAME_BITS);

  // Bit to drive is word[counter-1]; a counter of 16 has low nibble 0,
  // which wraps to 15 and selects the MSB.
  assign bit_sel = cnt_q[3:0] - 4'd1;

  // Next-state and next-output decode for the IDLE / SHIFT_LO / SHIFT_HI cycle
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cs_l_d  = cs_l_q;
    sclk_d  = sclk_q;
    data_d  = data_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        // One-cycle gap between frames; the only place datain is taken.
        cs_l_d  = 1'b1;
        sclk_d  = 1'b0;
        cnt_d   = FRAME_BITS;
        word_d  = datain;
        state_d = SHIFT_LO;
      end

      SHIFT_LO: begin
        if (!cnt_valid || cnt_q == 5'd0) begin
          cs_l_d  = 1'b1;
          sclk_d  = 1'b0;
          cnt_d   = FRAME_BITS;
          state_d = IDLE;
        end else begin
          // Present the bit a full clock before SCLK rises.
          cs_l_d  = 1'b0;
          sclk_d  = 1'b0;
          data_d  = word_q[bit_sel];
          cnt_d   = cnt_q - 5'd1;
          state_d = SHIFT_HI;
        end
      end

      SHIFT_HI: begin
        if (!cnt_valid) begin
          cs_l_d  = 1'b1;
          sclk_d  = 1'b0;
          cnt_d   = FRAME_BITS;
          state_d = IDLE;
        end else begin
          // Slave samples here; data and counter hold through the high phase.
          cs_l_d  = 1'b0;
          sclk_d  = 1'b1;
          state_d = (cnt_q == 5'd0) ? IDLE : SHIFT_LO;
        end
      end

      default: begin
        cs_l_d  = 1'b1;
        sclk_d  = 1'b0;
        cnt_d   = FRAME_BITS;
        state_d = IDLE;
      end
    endcase
  end

  // Single register stage for state and every output; reset aborts a frame at once
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= 16'h0000;
      cs_l_q  <= 1'b1;
      sclk_q  <= 1'b0;
      data_q  <= 1'b0;
      cnt_q   <= FRAME_BITS;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cs_l_q  <= cs_l_d;
      sclk_q  <= sclk_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign spi_cs_l = cs_l_q;
  assign spi_sclk = sclk_q;
  assign spi_data = data_q;
  assign counter  = cnt_q;

endmodule

// File: tb/tb_spi.sv
// tb/tb_spi.sv - self-checking bench for the spi serialiser
module tb_spi;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic [15:0] datain = 16'h0000;
  logic        spi_cs_l;
  logic        spi_sclk;
  logic        spi_data;
  logic [4:0]  counter;

  spi dut (
    .clk      (clk),
    .reset    (reset),
    .datain   (datain),
    .spi_cs_l (spi_cs_l),
    .spi_sclk (spi_sclk),
    .spi_data (spi_data),
    .counter  (counter)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp_v, exp_v, $time);
    end
  endtask

  // Frame-timing model and bit scoreboard
  int          cyc = 0;
  int          p;
  logic        bit_q[$];
  logic        cur_bit = 1'b0;
  logic        data_m  = 1'b0;
  logic [15:0] cap     = 16'h0000;
  logic [15:0] last_cap = 16'h0000;
  int          nbits = 0;
  int          frames_done = 0;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      cyc    = 0;
      nbits  = 0;
      data_m = 1'b0;
      bit_q.delete();
      chk("rst_cs",   int'(spi_cs_l), 1);
      chk("rst_sclk", int'(spi_sclk), 0);
      chk("rst_data", int'(spi_data), 0);
      chk("rst_cnt",  int'(counter),  16);
    end else begin
      cyc++;
      p = (cyc - 1) % 33;
      if (p == 0) begin
        chk("idle_cs",   int'(spi_cs_l), 1);
        chk("idle_sclk", int'(spi_sclk), 0);
        chk("idle_cnt",  int'(counter),  16);
        chk("idle_data_hold", int'(spi_data), int'(data_m));
        for (int i = 15; i >= 0; i--) bit_q.push_back(datain[i]);
        cap   = 16'h0000;
        nbits = 0;
      end else if (p % 2 == 1) begin
        if (bit_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          cur_bit = bit_q.pop_front();
        end
        data_m = cur_bit;
        chk("lo_cs",   int'(spi_cs_l), 0);
        chk("lo_sclk", int'(spi_sclk), 0);
        chk("lo_cnt",  int'(counter),  16 - (p + 1) / 2);
        chk("lo_data", int'(spi_data), int'(cur_bit));
      end else begin
        chk("hi_cs",   int'(spi_cs_l), 0);
        chk("hi_sclk", int'(spi_sclk), 1);
        chk("hi_cnt",  int'(counter),  16 - p / 2);
        chk("hi_data", int'(spi_data), int'(cur_bit));
        cap = {cap[14:0], spi_data};
        nbits++;
        if (nbits == 16) begin
          last_cap = cap;
          frames_done++;
        end
      end
    end
  end

  // Wait for n more completed frames; returns on the negedge before the next IDLE edge
  task automatic wait_frames(input int n);
    int start;
    int t;
    start = frames_done;
    t = 0;
    while (frames_done < start + n && t < 40 * n + 40) begin
      @(negedge clk);
      t++;
    end
    if (frames_done < start + n) chk("frame_timeout", frames_done, start + n);
  endtask

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp_serial;
    int          exp_ones;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'hA569, 16'b1010_0101_0110_1001, 8};
    vecs[1] = '{16'h2563, 16'b0010_0101_0110_0011, 7};
    vecs[2] = '{16'h0000, 16'b0000_0000_0000_0000, 0};
    vecs[3] = '{16'hFFFF, 16'b1111_1111_1111_1111, 16};
    vecs[4] = '{16'h9B63, 16'b1001_1011_0110_0011, 9};
    vecs[5] = '{16'h7564, 16'b0111_0101_0110_0100, 8};

    // Reset held two cycles, then release with A569 waiting
    reset  = 1'b1;
    datain = 16'hA569;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("first_edge_cs",  int'(spi_cs_l), 1);
    chk("first_edge_cnt", int'(counter),  16);
    @(posedge clk); #1;
    chk("second_edge_cs",   int'(spi_cs_l), 0);
    chk("second_edge_cnt",  int'(counter),  15);
    chk("second_edge_data", int'(spi_data), 1);
    wait_frames(1);
    chk("first_frame", int'(last_cap), 16'hA569);

    // Table: one frame per vector, datain changed at each frame boundary
    for (int v = 0; v < 6; v++) begin
      datain = vecs[v].din;
      wait_frames(1);
      chk("tbl_serial", int'(last_cap), int'(vecs[v].exp_serial));
      chk("tbl_ones",   $countones(last_cap), vecs[v].exp_ones);
    end

    // Continuous frames with a held word
    datain = 16'h2563;
    wait_frames(2);
    chk("cont_2563", int'(last_cap), 16'h2563);

    // Mid-frame datain change has no effect on the frame in flight
    datain = 16'h9B63;
    repeat (17) @(negedge clk);
    datain = 16'h6A61;
    wait_frames(1);
    chk("mid_cur", int'(last_cap), 16'h9B63);
    wait_frames(1);
    chk("mid_next", int'(last_cap), 16'h6A61);

    // Reset during bit 5 of A265 aborts the frame on the same edge
    datain = 16'hA265;
    repeat (11) @(negedge clk);
    reset  = 1'b1;
    datain = 16'h7564;
    @(posedge clk); #1;
    chk("abort_cs",   int'(spi_cs_l), 1);
    chk("abort_sclk", int'(spi_sclk), 0);
    chk("abort_cnt",  int'(counter),  16);
    @(negedge clk);
    reset = 1'b0;
    wait_frames(1);
    chk("after_abort", int'(last_cap), 16'h7564);

    // Boundary words back to back
    datain = 16'h0000;
    wait_frames(1);
    chk("zeros", int'(last_cap), 16'h0000);
    datain = 16'hFFFF;
    wait_frames(1);
    chk("ones", int'(last_cap), 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi.md
Name: spi

Overview:
- Free-running 16-bit SPI master transmitter, MSB first, with an active-low chip select.
- Sends the parallel word on `datain` serially, one frame after another, with no gaps other than one idle cycle.
- SCLK is derived from the system clock: one SCLK period is two system clocks.
- Used as the SPI-side serialiser behind the AHB-Lite bridge; a bit counter is exported for debug and monitoring.

Parameters:
- None. Frame width is fixed at 16 bits and counter width at 5 bits.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- datain  input  16  parallel word to transmit; sampled only in the IDLE state.
- spi_cs_l  output  1  chip select, active low; low for the whole frame.
- spi_sclk  output  1  serial clock, idles low (CPOL=0); the slave samples on its rising edge.
- spi_data  output  1  serial data (MOSI), MSB first.
- counter  output  5  bits remaining in the current frame (16 down to 0).

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high. All outputs are registered; nothing is combinational from inputs to outputs.
- Reset (reset=1 at a rising edge), in the same edge:
  - state=IDLE
  - spi_cs_l=1, spi_sclk=0, spi_data=0, counter=16
  - internal shift word=0
- Reset has priority over everything. Asserting reset mid-frame aborts the frame immediately: CS goes high and SCLK goes low on that edge. No partial-frame completion.
- State machine has three states: IDLE, SHIFT_LO, SHIFT_HI.
- IDLE (lasts 1 cycle):
  - spi_cs_l=1, spi_sclk=0, counter=16
  - latch datain into the internal word
  - spi_data holds its previous value
  - next state: SHIFT_LO (unconditional; transfers are continuous)
- SHIFT_LO:
  - spi_cs_l=0, spi_sclk=0
  - spi_data = word[counter-1], using the counter value before the decrement
  - counter = counter-1
  - next state: SHIFT_HI
- SHIFT_HI:
  - spi_sclk=1; spi_cs_l stays 0; spi_data and counter hold
  - if counter==0, next state is IDLE; otherwise SHIFT_LO
- Frame timing:
  - 1 IDLE cycle plus 16 × 2 shift cycles = 33-clock frame period.
  - CS is low for 32 consecutive cycles per frame.
  - Each data bit is stable one clock before the SCLK rising edge and through the SCLK high phase.
- Latency: the first SHIFT_LO edge comes one clock after the IDLE edge that latched datain. The first edge after reset release is an IDLE edge.
- datain changes during a frame have no effect. The new value is taken at the next IDLE edge.
- Bit order: 16 SCLK rising edges per frame carry word[15], word[14], …, word[0].
- Counter sequence as seen after each edge: 16 (IDLE), 15, 15, 14, 14, …, 0, 0, then 16 again.
- counter never goes below 0 and never exceeds 16. Values 17–31 are unreachable; if ever seen in state logic, return to IDLE.
- The SPI clock is generated as a registered output in the clk domain, never by gating clk.

Test Plan:
- Reset held 2 cycles -> spi_cs_l=1, spi_sclk=0, spi_data=0, counter=16. Release -> first edge IDLE (cs=1), second edge cs=0, counter=15, spi_data=bit15.
- datain=16'hA569 before an IDLE edge -> the 16 bits sampled on SCLK rising edges are 1010_0101_0110_1001; counter reaches 0, then the next edge gives cs=1, counter=16.
- Continuous frames: datain=16'h2563 held -> CS high for exactly 1 cycle every 33 cycles and low for 32; 16 SCLK pulses per frame, each 1 high cycle and 1 low cycle.
- Mid-frame change: frame sending 16'h9B63, datain switched to 16'h6A61 at bit 8 -> current frame still completes 9B63; next frame sends 6A61.
- Reset mid-frame (during bit 5 of 16'hA265) -> same edge: cs=1, sclk=0, counter=16; after release a full new frame sends the current datain (16'h7564).
- Boundary: datain=16'h0000 then 16'hFFFF -> spi_data constant 0, then constant 1, across each frame; counter and SCLK pattern unchanged.
